// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and LSU writeback.
// Optional zeroing sweep of x1..x31 is compiled in with `define REGFILE_ARB_CLEAR_EN.
module regfile_wr_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [4:0]       req0_rd,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_rd,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             wr_we,
  output logic [4:0]       wr_rd,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             prio_q, prio_d;
  logic             wr_we_q, wr_we_d;
  logic [4:0]       wr_rd_q, wr_rd_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic idle;
  logic clear_start;
  logic both_valid;
  logic grant0, grant1;
  logic xfer0, xfer1;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0] state_q, state_d;
  logic [4:0] index_q, index_d;

  assign idle        = (state_q == ST_IDLE);
  assign clear_start = idle && clear_req;
  assign clear_busy  = (state_q == ST_CLEAR);
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign idle             = 1'b1;
  assign clear_start      = 1'b0;
  assign clear_busy       = 1'b0;
`endif

  assign both_valid = req0_valid && req1_valid;
  assign grant0     = req0_valid && (!req1_valid || !prio_q);
  assign grant1     = req1_valid && (!req0_valid ||  prio_q);

  // Readys are also held low while reset is asserted so nothing handshakes that cycle.
  assign req0_ready = reset && idle && !clear_start && grant0;
  assign req1_ready = reset && idle && !clear_start && grant1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  always_comb begin
    prio_d    = prio_q;
    wr_we_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    if (both_valid && idle && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // x0 writes still handshake and rotate priority, but never assert the write enable.
    if (xfer0) begin
      wr_we_d   = |req0_rd;
      wr_rd_d   = req0_rd;
      wr_data_d = req0_data;
      prio_d    = 1'b1;
    end else if (xfer1) begin
      wr_we_d   = |req1_rd;
      wr_rd_d   = req1_rd;
      wr_data_d = req1_data;
      prio_d    = 1'b0;
    end

`ifdef REGFILE_ARB_CLEAR_EN
    state_d = state_q;
    index_d = index_q;
    if (clear_start) begin
      state_d = ST_CLEAR;
      index_d = 5'd1;
    end else if (state_q == ST_CLEAR) begin
      wr_we_d   = 1'b1;
      wr_rd_d   = index_q;
      wr_data_d = '0;
      index_d   = index_q + 5'd1;
      if (index_q == 5'd31) begin
        state_d = ST_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q    <= 1'b0;
      wr_we_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_we_q   <= wr_we_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef REGFILE_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      index_q <= 5'd1;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end
`endif

  assign wr_we        = wr_we_q;
  assign wr_rd        = wr_rd_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a cycle-level behavioural model.
// Runs two instances (CNT_W=16 and CNT_W=4) on the same stimulus to cover counter saturation.
module tb_regfile_wr_arbiter;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, clr;
  logic [4:0]  rd0, rd1;
  logic [31:0] d0, d1;

  logic        r0, r1, busy, we;
  logic [4:0]  wrd;
  logic [31:0] wdat;
  logic [15:0] cnt;
  logic        r0_s, r1_s, busy_s, we_s;
  logic [4:0]  wrd_s;
  logic [31:0] wdat_s;
  logic [3:0]  cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending clear writes, priority, expected command, raw contention count.
  int          m_left, m_prio, m_cnt;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_rf [32];
  logic [31:0] tb_rf [32];
  logic        rf_clr;
  bit          acc0, acc1;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0), .req0_rd(rd0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_rd(rd1), .req1_data(d1), .req1_ready(r1),
    .clear_req(clr), .clear_busy(busy),
    .wr_we(we), .wr_rd(wrd), .wr_data(wdat), .conflict_cnt(cnt)
  );

  regfile_wr_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0), .req0_rd(rd0), .req0_data(d0), .req0_ready(r0_s),
    .req1_valid(v1), .req1_rd(rd1), .req1_data(d1), .req1_ready(r1_s),
    .clear_req(clr), .clear_busy(busy_s),
    .wr_we(we_s), .wr_rd(wrd_s), .wr_data(wdat_s), .conflict_cnt(cnt_s)
  );

  // Register file fed by the DUT's write command.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
    end else if (we) begin
      tb_rf[wrd] <= wdat;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock: check readys mid-low-phase, advance the model, check registered outputs after the edge.
  task automatic cycle();
    int  g;
    bit  clr_eff, e0, e1;
    @(negedge clk);
    #1;
    clr_eff = CLEAR_EN && clr && (m_left == 0);
    g = -1;
    if (v0 && v1) g = m_prio;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    e0 = rst_n && (m_left == 0) && !clr_eff && (g == 0);
    e1 = rst_n && (m_left == 0) && !clr_eff && (g == 1);
    check("req0_ready", r0, e0);
    check("req1_ready", r1, e1);
    check("req0_ready_sat", r0_s, e0);
    check("req1_ready_sat", r1_s, e1);
    acc0 = e0;
    acc1 = e1;

    if (!rst_n) begin
      m_prio = 0; m_left = 0; m_cnt = 0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else if (m_left > 0) begin
      m_we = 1'b1; m_rd = 5'(32 - m_left); m_data = '0;
      m_rf[32 - m_left] = '0;
      m_left--;
    end else begin
      if (v0 && v1) m_cnt++;
      if (clr_eff) begin
        m_left = 31; m_we = 1'b0;
      end else if (g == 0) begin
        m_we = (rd0 != 0); m_rd = rd0; m_data = d0; m_prio = 1;
        if (rd0 != 0) m_rf[rd0] = d0;
      end else if (g == 1) begin
        m_we = (rd1 != 0); m_rd = rd1; m_data = d1; m_prio = 0;
        if (rd1 != 0) m_rf[rd1] = d1;
      end else begin
        m_we = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    check("wr_we", we, m_we);
    check("wr_rd", wrd, m_rd);
    check("wr_data", wdat, m_data);
    check("clear_busy", busy, (m_left > 0));
    check("conflict_cnt", cnt, sat(m_cnt, 65535));
    check("conflict_cnt_sat", cnt_s, sat(m_cnt, 15));
    check("wr_we_sat", we_s, m_we);
    check("wr_rd_sat", wrd_s, m_rd);
  endtask

  // Requesters keep an un-accepted request stable; otherwise they may present a new one.
  task automatic refresh(input int pct);
    if (!v0 || acc0) begin
      v0  = ($urandom_range(0, 99) < pct);
      rd0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d0  = $urandom;
    end
    if (!v1 || acc1) begin
      v1  = ($urandom_range(0, 99) < pct);
      rd1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d1  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    rst_n = 1'b0; clr = 1'b0; rf_clr = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
    m_left = 0; m_prio = 0; m_cnt = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;

    // Reset with a request present: it must not be accepted.
    v0 = 1'b1; rd0 = 5'd9; d0 = 32'h1111_2222;
    cycle();
    cycle();
    rf_clr = 1'b0;
    rst_n  = 1'b1;
    v0 = 1'b0;

    // Single requester.
    v0 = 1'b1; rd0 = 5'd5; d0 = 32'hDEAD_BEEF;
    cycle();
    v0 = 1'b0;
    cycle();

    // Round-robin from prio=0 with both requesters continuously valid.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; rd0 = 5'd1; d0 = 32'h100 + 32'(i);
      v1 = 1'b1; rd1 = 5'd2; d1 = 32'h200 + 32'(i);
      cycle();
    end
    v0 = 1'b0; v1 = 1'b0;
    cycle();

    // x0 write from requester 1, then a contended cycle must go to requester 0.
    v1 = 1'b1; rd1 = 5'd0; d1 = 32'h1234;
    cycle();
    v0 = 1'b1; rd0 = 5'd3; d0 = 32'h3333; rd1 = 5'd4; d1 = 32'h4444;
    cycle();
    v0 = 1'b0;
    cycle();
    v1 = 1'b0;

    // Clear sweep with requests present and a repeated clear_req mid-sweep.
    v0 = 1'b1; rd0 = 5'd7; d0 = 32'hA5A5_A5A5;
    cycle();
    v0 = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    busy_cycles = 0;
    v0 = 1'b1; rd0 = 5'd12; d0 = 32'hCAFE_0001;
    v1 = 1'b1; rd1 = 5'd13; d1 = 32'hCAFE_0002;
    for (int i = 0; i < 31; i++) begin
      if (busy) busy_cycles++;
      clr = (i == 15);
      cycle();
      clr = 1'b0;
      if (acc0 || acc1) refresh(100);
    end
    check("clear_busy_cycles", busy_cycles, CLEAR_EN ? 31 : 0);
    v0 = 1'b0; v1 = 1'b0;
    cycle();
    cycle();
    check("x7_after_clear", tb_rf[7], CLEAR_EN ? 32'h0 : 32'hA5A5_A5A5);

    // Reset at sweep step 10, then a contended request must go to requester 0.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    do_reset();
    v0 = 1'b1; rd0 = 5'd20; d0 = 32'h2020_2020;
    v1 = 1'b1; rd1 = 5'd21; d1 = 32'h2121_2121;
    cycle();
    v0 = 1'b0;
    cycle();
    v1 = 1'b0;

    // Saturation of the 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v0 = 1'b1; rd0 = 5'($urandom_range(1, 31)); d0 = $urandom;
      v1 = 1'b1; rd1 = 5'($urandom_range(1, 31)); d1 = $urandom;
      cycle();
    end
    check("conflict_cnt_sat_final", cnt_s, 4'd15);
    v0 = 1'b0; v1 = 1'b0;

    // Randomized traffic with occasional clears and resets.
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      refresh(60);
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
    end
    clr = 1'b0; rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 34; i++) cycle();

    for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), tb_rf[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load/store writeback). It grants by round-robin with a valid/ready handshake and drives a registered write command (we/rd/wdata) into the register file. An optional clear sequencer sweeps zeros through x1..x31 through the same port. It also counts contention cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of saturating contention counter

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- req0_valid  in  1  requester 0 has a write pending
- req0_rd  in  5  requester 0 destination register
- req0_data  in  32  requester 0 write data
- req0_ready  out  1  requester 0 transfer accepted this cycle (combinational)
- req1_valid / req1_rd / req1_data / req1_ready  same as requester 0, for requester 1
- clear_req  in  1  request zeroing of x1..x31 (single-cycle pulse)
- clear_busy  out  1  clear sweep in progress
- wr_we  out  1  register file write enable (registered)
- wr_rd  out  5  register file destination address (registered)
- wr_data  out  32  register file write data (registered)
- conflict_cnt  out  CNT_W  cycles in which both requests were valid and one had to wait (saturating)

## Operation
- FSM states: IDLE and CLEAR. CLEAR exists only with the macro.
- IDLE arbitration:
  - Only one request valid: that requester gets ready=1.
  - Both valid: the requester holding priority wins. The priority pointer `prio` starts at 0.
  - After any grant, `prio` moves to the other requester, so the last winner becomes lowest priority.
- Ready is combinational: `reqN_ready = state==IDLE && !clear_req && grantN`. A transfer happens when valid && ready.
- A transfer at edge E loads the outputs at E: wr_we=1, wr_rd=rd, wr_data=data. The command is visible during the next cycle.
- No transfer at an edge: wr_we<=0. wr_rd and wr_data hold their values.
- rd==0 requests:
  - Accepted and handshaken normally, and `prio` is updated.
  - wr_we<=0 for that transfer, because x0 is never written.
- conflict_cnt increments by 1 on every edge where both valids are 1 and state is IDLE. It saturates at all-ones and never wraps.
- Clear sweep:
  - clear_req=1 in IDLE enters CLEAR and sets index=1. No grant is issued that cycle; clear beats any valid request.
  - Each CLEAR edge drives wr_we<=1, wr_rd<=index, wr_data<=0, then increments index.
  - The edge that writes index 31 returns the FSM to IDLE.
- In CLEAR: both readys are 0, `prio` is frozen, and conflict_cnt is frozen.
- clear_req asserted while in CLEAR is ignored; it is neither queued nor restarted.
- reset=0 at any edge, including mid-sweep or mid-handshake:
  - state=IDLE, index=1, prio=0.
  - wr_we=0, wr_rd=0, wr_data=0, conflict_cnt=0, clear_busy=0.
  - Any request presented that cycle is not accepted.

## Timing
- Grant to register file write: 1 cycle. A request accepted at edge E is written into the register file at edge E+1.
- Throughput: one write per cycle. Back-to-back transfers from the same requester are allowed when the other requester is idle.
- Worst-case wait under contention: 1 cycle.
- Clear:
  - clear_req sampled at edge N.
  - clear_busy is high from after N through edge N+31, i.e. 31 cycles.
  - Writes to x1..x31 appear at edges N+1..N+31.
  - Readys can be 1 again in the cycle after N+31.
- Outputs after reset: all 0. req0_ready and req1_ready follow the valids combinationally from the first cycle after reset.
- Requesters must hold valid, rd and data stable until ready.

## Configuration
- Macro: REGFILE_ARB_CLEAR_EN.
- Defined: the CLEAR state, the index counter and the clear sweep are compiled in, as described above.
- Undefined:
  - clear_req is ignored and clear_busy is tied to 0.
  - The FSM is permanently IDLE.
  - All other behaviour is identical.

## Test plan
- Reset then single requester: req0 valid, rd=5, data=0xDEADBEEF, sampled at edge E → req0_ready=1 in that cycle; wr_we=1, wr_rd=5, wr_data=0xDEADBEEF during the following cycle.
- Round-robin: both valid for 4 cycles (rd=1/2), starting from prio=0 → grants in order 0,1,0,1; conflict_cnt increments each cycle while both are valid.
- rd=0: req1 valid with rd=0, data=0x1234 → req1_ready=1 and wr_we=0; the next grant goes to req0.
- Clear (macro defined): write x7=0xA5A5A5A5, then pulse clear_req → clear_busy high for exactly 31 cycles; wr_rd steps 1..31 with wr_data=0; register file reads x7=0; readys stay 0 throughout even with valid requests present; clear_req during the sweep has no effect.
- Reset mid-sweep: reset=0 at sweep step 10 → clear_busy=0, wr_we=0, conflict_cnt=0 next cycle; a subsequent req0 grant works with prio=0.
- Saturation (CNT_W=4): both valid for 20 cycles → conflict_cnt stops at 15.
